arbitro_bus4: RTL
=================

ARBITRO_BUS4 -- requirements
Module: arbitro_bus4

Interface
REQ-001 SHALL have parameter: WIDTH, 32, data width of each requester port and of datoOutput.
REQ-002 SHALL have parameter: MAX_HOLD, 8, maximum beats per grant when ARB_TIMEOUT_EN is defined (legal range 1..255).
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port: req  input  4  request per requester; bit 0 = A, 1 = B, 2 = C, 3 = D.
REQ-006 SHALL have port: last  input  4  per-requester final-beat marker, sampled only with req of the owner.
REQ-007 SHALL have ports: datoA, datoB, datoC, datoD  input  WIDTH  requester data.
REQ-008 SHALL have port: gnt  output  4  one-hot grant, all zero when no owner.
REQ-009 SHALL have port: selDato  output  2  select code for the shared 4:1 multiplexer (00=A, 01=B, 10=C, 11=D).
REQ-010 SHALL have port: datoOutput  output  WIDTH  registered shared-bus data.
REQ-011 SHALL have port: valid  output  1  registered; high when datoOutput holds an accepted beat.

Function
REQ-012 SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-013 IDLE: when req != 0, the arbiter SHALL pick the first set bit searching ptr, ptr+1, ... (mod 4), set gnt/selDato to it and enter GRANT on the next edge. Grant latency is 1 cycle.
REQ-014 IDLE with req == 0 SHALL remain in IDLE with gnt = 0 and selDato held.
REQ-015 GRANT: each cycle with req[owner] = 1 is a beat. On the next edge datoOutput SHALL equal the selected dato and valid SHALL be 1.
REQ-016 GRANT: a cycle with req[owner] = 0 is not a beat. Next edge: valid = 0, datoOutput held, release.
REQ-017 Release on a beat with last[owner] = 1, or on req[owner] = 0. Next edge: IDLE, gnt = 0, ptr = owner+1 mod 4 (3 wraps to 0).
REQ-018 After every release the arbiter SHALL spend exactly one cycle in IDLE before any new grant (one-cycle bubble).
REQ-019 Requests from non-owners during GRANT SHALL be ignored. The owner SHALL NOT be preempted except by REQ-025.
REQ-020 gnt SHALL always be one-hot or zero, and selDato SHALL always match the set gnt bit.
REQ-021 last bits of non-owners and last without req SHALL have no effect.

Reset
REQ-022 With rst = 1 at an edge: state = IDLE, gnt = 0, selDato = 00, datoOutput = 0, valid = 0, ptr = 0, hold counter = 0.
REQ-023 Reset mid-grant SHALL abort the grant immediately, with no completion beat emitted. rst has priority over all other inputs.
REQ-024 The first grant after reset SHALL go to the lowest set bit of req (ptr = 0).

Configuration
REQ-025 Macro ARB_TIMEOUT_EN defined: an 8-bit hold counter counts beats per grant. The MAX_HOLD-th beat SHALL be treated as last (forced release per REQ-017) and captured normally.
REQ-026 Macro ARB_TIMEOUT_EN undefined: no hold counter exists, and a grant persists until last or req drop, unbounded.

Verification
REQ-027 After reset, req = 0101, datoA = 1, datoC = 3, last = 0001 held:
- gnt = 0001 one cycle later, valid with datoOutput = 1 the next cycle.
- Then one IDLE cycle, then gnt = 0100, selDato = 10.
REQ-028 req = 1111 continuously, last = 1111:
- Grants cycle A, B, C, D, A with a one-bubble gap.
- datoOutput sequence 1, 2, 3, 4, 1 (datoA..D = 1..4).
REQ-029 B owner, req[1] dropped mid-grant:
- valid = 0 next edge, gnt = 0.
- ptr = 2: with req = 0011, C is absent, so A is skipped? No: the search starts at C, D, A, so A is granted next.
REQ-030 rst pulsed while D is owner: next edge gnt = 0, valid = 0, datoOutput = 0; the next grant with req = 1000 goes to D via ptr = 0 search.
REQ-031 With ARB_TIMEOUT_EN defined, MAX_HOLD = 8, and req = 0011 with last = 0:
- A gets exactly 8 valid beats, then the bubble, then B is granted.
- Without the macro, A holds indefinitely (checked over 100 cycles).

Source files
------------

// File: rtl/arbitro_bus4.sv
// arbitro_bus4: four-requester bus arbiter with rotating priority.
// An owner keeps the shared bus until it marks a beat with last or drops its
// request. Every release is followed by exactly one idle cycle. The search for
// the next owner starts at the requester after the previous owner.
// Optional build macro ARB_TIMEOUT_EN caps each grant at MAX_HOLD beats.
//
//   state | meaning
//   IDLE  | no owner; the next requester is chosen from ptr onward
//   GRANT | one owner; its beats are captured onto datoOutput
module arbitro_bus4 #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] datoA,
  input  logic [WIDTH-1:0] datoB,
  input  logic [WIDTH-1:0] datoC,
  input  logic [WIDTH-1:0] datoD,
  output logic [3:0]       gnt,
  output logic [1:0]       selDato,
  output logic [WIDTH-1:0] datoOutput,
  output logic             valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [1:0]       ptr;
  logic [1:0]       pick;
  logic             pick_any;
  logic [WIDTH-1:0] dato_sel;
  logic             owner_req;
  logic             owner_last;
  logic             hold_hit;
  logic             release_now;

  // The hold limit is an 8-bit count; catch an illegal setting at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arbitro_bus4: MAX_HOLD must be in 1..255");
  end

  // Rotating search: the smallest offset from ptr with a set request wins.
  always_comb begin
    pick     = ptr;
    pick_any = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (req[ptr + 2'(k)]) begin
        pick     = ptr + 2'(k);
        pick_any = 1'b1;
      end
    end
  end

  // Shared 4:1 data multiplexer driven by the registered select code.
  always_comb begin
    dato_sel = datoA;
    case (selDato)
      2'd0: dato_sel = datoA;
      2'd1: dato_sel = datoB;
      2'd2: dato_sel = datoC;
      2'd3: dato_sel = datoD;
      default: dato_sel = datoA;
    endcase
  end

  assign owner_req  = req[selDato];
  assign owner_last = last[selDato];

`ifdef ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  // A beat that would be the MAX_HOLD-th of this grant is treated as last.
  assign hold_hit = owner_req && (hold_cnt == 8'(MAX_HOLD - 1));

  // Count beats of the current grant; cleared whenever there is no ongoing grant.
  always_ff @(posedge clk) begin
    if (rst || state != GRANT || release_now) begin
      hold_cnt <= 8'd0;
    end else if (owner_req) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  // A non-beat cycle always ends the grant, as does a beat marked last.
  assign release_now = (state == GRANT) && (!owner_req || owner_last || hold_hit);

  // Arbiter FSM with registered grant, select and captured bus data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      gnt        <= 4'b0000;
      selDato    <= 2'd0;
      datoOutput <= '0;
      valid      <= 1'b0;
      ptr        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          valid <= 1'b0;
          if (pick_any) begin
            state   <= GRANT;
            gnt     <= 4'b0001 << pick;
            selDato <= pick;
          end else begin
            gnt <= 4'b0000;
          end
        end
        GRANT: begin
          if (owner_req) begin
            datoOutput <= dato_sel;
            valid      <= 1'b1;
          end else begin
            valid <= 1'b0;
          end
          if (release_now) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            ptr   <= selDato + 2'd1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= 4'b0000;
          valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
